// File: rtl/wavegen.sv
// Multi-channel test-tone generator: per-channel phase accumulators producing
// triangle/saw/square/silence, served round-robin over a pop/ack pull port.
// Optional per-channel amplitude attenuation is compiled in with WAVEGEN_AMP_EN.
module wavegen #(
    parameter int WIDTH = 24,
    parameter int NCH   = 2,
    parameter int ACC_W = 32,
    parameter int CH_W  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pop_i,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [ACC_W-1:0] cfg_inc,
    input  logic             cfg_clr,
`ifdef WAVEGEN_AMP_EN
    input  logic [2:0]       cfg_shift,
`endif
    output logic             ack_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CH_W-1:0]  ch_o
);

    typedef enum logic [1:0] {
        MODE_SILENT = 2'd0,
        MODE_TRI    = 2'd1,
        MODE_SAW    = 2'd2,
        MODE_SQR    = 2'd3
    } mode_t;

    localparam logic [WIDTH-1:0] HALF    = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] SQR_POS = HALF - WIDTH'(1);
    localparam logic [WIDTH-1:0] SQR_NEG = HALF + WIDTH'(1);

    logic [ACC_W-1:0] phase [NCH];
    logic [ACC_W-1:0] inc   [NCH];
    mode_t            mode  [NCH];
`ifdef WAVEGEN_AMP_EN
    logic [2:0]       shift [NCH];
`endif
    logic [CH_W-1:0]  cur;

    logic [WIDTH-1:0] tri_u;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] sample;
    logic             cfg_hit;

    assign cfg_hit = cfg_we && (int'(cfg_ch) < NCH);

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        raw   = '0;
        tri_u = phase[cur][ACC_W-2 -: WIDTH];
        case (mode[cur])
            MODE_SILENT: raw = '0;
            MODE_TRI:    raw = (phase[cur][ACC_W-1] ? ~tri_u : tri_u) ^ HALF;
            MODE_SAW:    raw = phase[cur][ACC_W-1 -: WIDTH] ^ HALF;
            MODE_SQR:    raw = phase[cur][ACC_W-1] ? SQR_NEG : SQR_POS;
            default:     raw = '0;
        endcase
`ifdef WAVEGEN_AMP_EN
        sample = $signed(raw) >>> shift[cur];
`else
        sample = raw;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // read in this block sees the pre-edge value (the pop uses old config).
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_o  <= 1'b0;
            data_o <= '0;
            ch_o   <= '0;
            cur    <= '0;
            // NOTE: the channel tables are reset because a fresh start must
            // come up silent at phase 0; they are small register arrays, not RAM.
            for (int i = 0; i < NCH; i++) begin
                phase[i] <= '0;
                inc[i]   <= '0;
                mode[i]  <= MODE_SILENT;
`ifdef WAVEGEN_AMP_EN
                shift[i] <= '0;
`endif
            end
        end else begin
            if (pop_i) begin
                phase[cur] <= phase[cur] + inc[cur];
                cur        <= (int'(cur) == NCH - 1) ? '0 : cur + CH_W'(1);
                ack_o      <= 1'b1;
                data_o     <= sample;
                ch_o       <= cur;
            end else begin
                ack_o  <= 1'b0;
                data_o <= '0;
                ch_o   <= '0;
            end
            // Placed after the pop update so a clear wins on a collision.
            if (cfg_hit) begin
                mode[cfg_ch] <= mode_t'(cfg_mode);
                inc[cfg_ch]  <= cfg_inc;
`ifdef WAVEGEN_AMP_EN
                shift[cfg_ch] <= cfg_shift;
`endif
                if (cfg_clr) begin
                    phase[cfg_ch] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_wavegen.sv
// Self-checking bench for wavegen (default build, NCH=2): table-driven vectors
// plus hand-written saw-wrap, config/pop collision and mid-stream reset sequences.
module tb_wavegen;

    localparam int WIDTH = 24;
    localparam int NCH   = 2;
    localparam int ACC_W = 32;
    localparam int CH_W  = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pop_i = 1'b0;
    logic             cfg_we = 1'b0;
    logic [CH_W-1:0]  cfg_ch = '0;
    logic [1:0]       cfg_mode = '0;
    logic [ACC_W-1:0] cfg_inc = '0;
    logic             cfg_clr = 1'b0;
    logic             ack_o;
    logic [WIDTH-1:0] data_o;
    logic [CH_W-1:0]  ch_o;

    int n_checks = 0;
    int n_fail   = 0;

    wavegen #(.WIDTH(WIDTH), .NCH(NCH), .ACC_W(ACC_W), .CH_W(CH_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .pop_i    (pop_i),
        .ack_o    (ack_o),
        .data_o   (data_o),
        .ch_o     (ch_o),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_inc  (cfg_inc),
        .cfg_clr  (cfg_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             pop;
        logic             we;
        logic [1:0]       mode;
        logic [ACC_W-1:0] inc;
        logic             clr;
        logic             ack;
        logic [WIDTH-1:0] data;
        logic [CH_W-1:0]  ch;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, clock, then sample outputs 1 time unit later.
    task automatic step(input string name, input logic pop, input logic we,
                        input logic [1:0] mode, input logic [ACC_W-1:0] inc,
                        input logic clr, input logic exp_ack,
                        input logic [WIDTH-1:0] exp_data, input logic [CH_W-1:0] exp_ch);
        pop_i    = pop;
        cfg_we   = we;
        cfg_ch   = '0;
        cfg_mode = mode;
        cfg_inc  = inc;
        cfg_clr  = clr;
        @(posedge clk);
        #1;
        check({name, ".ack"}, 32'(ack_o), 32'(exp_ack));
        check({name, ".data"}, 32'(data_o), 32'(exp_data));
        check({name, ".ch"}, 32'(ch_o), 32'(exp_ch));
    endtask

    function automatic vec_t v_pop(input logic [WIDTH-1:0] d, input logic [CH_W-1:0] c);
        vec_t v = '{pop: 1'b1, we: 1'b0, mode: 2'd0, inc: '0, clr: 1'b0,
                    ack: 1'b1, data: d, ch: c};
        return v;
    endfunction

    function automatic vec_t v_cfg(input logic [1:0] m, input logic [ACC_W-1:0] i);
        vec_t v = '{pop: 1'b0, we: 1'b1, mode: m, inc: i, clr: 1'b1,
                    ack: 1'b0, data: '0, ch: '0};
        return v;
    endfunction

    function automatic vec_t v_idle();
        vec_t v = '{pop: 1'b0, we: 1'b0, mode: 2'd0, inc: '0, clr: 1'b0,
                    ack: 1'b0, data: '0, ch: '0};
        return v;
    endfunction

    initial begin
        // Silent after reset: five pops alternate channels, then idle.
        for (int i = 0; i < 5; i++) tbl.push_back(v_pop(24'h0, CH_W'(i % 2)));
        tbl.push_back(v_idle());
        tbl.push_back(v_pop(24'h0, 1'b1));
        // Square on ch0, inc = quarter turn.
        tbl.push_back(v_cfg(2'd3, 32'h4000_0000));
        tbl.push_back(v_pop(24'h7FFFFF, 1'b0)); tbl.push_back(v_pop(24'h0, 1'b1));
        tbl.push_back(v_pop(24'h7FFFFF, 1'b0)); tbl.push_back(v_pop(24'h0, 1'b1));
        tbl.push_back(v_pop(24'h800001, 1'b0)); tbl.push_back(v_pop(24'h0, 1'b1));
        tbl.push_back(v_pop(24'h800001, 1'b0)); tbl.push_back(v_pop(24'h0, 1'b1));
        tbl.push_back(v_pop(24'h7FFFFF, 1'b0)); tbl.push_back(v_pop(24'h0, 1'b1));
        // Triangle on ch0, inc = quarter turn.
        tbl.push_back(v_cfg(2'd1, 32'h4000_0000));
        tbl.push_back(v_pop(24'h800000, 1'b0)); tbl.push_back(v_pop(24'h0, 1'b1));
        tbl.push_back(v_pop(24'h000000, 1'b0)); tbl.push_back(v_pop(24'h0, 1'b1));
        tbl.push_back(v_pop(24'h7FFFFF, 1'b0)); tbl.push_back(v_pop(24'h0, 1'b1));
        tbl.push_back(v_pop(24'hFFFFFF, 1'b0)); tbl.push_back(v_pop(24'h0, 1'b1));
        tbl.push_back(v_pop(24'h800000, 1'b0)); tbl.push_back(v_pop(24'h0, 1'b1));

        repeat (2) @(posedge clk);
        #1;
        check("reset.ack", 32'(ack_o), 32'd0);
        check("reset.data", 32'(data_o), 32'd0);
        check("reset.ch", 32'(ch_o), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].pop, tbl[i].we, tbl[i].mode,
                 tbl[i].inc, tbl[i].clr, tbl[i].ack, tbl[i].data, tbl[i].ch);
        end

        // Saw on ch0: steps of 0x010000 from 0x800000, wrapping after 256 pops.
        step("saw_cfg", 1'b0, 1'b1, 2'd2, 32'h0100_0000, 1'b1, 1'b0, 24'h0, 1'b0);
        for (int k = 0; k < 256; k++) begin
            logic [7:0] kb;
            kb = 8'(k);
            step($sformatf("saw%0d", k), 1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b1,
                 {kb ^ 8'h80, 16'h0}, 1'b0);
            step($sformatf("saw%0d_ch1", k), 1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b1, 24'h0, 1'b1);
        end
        step("saw_wrap", 1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b1, 24'h800000, 1'b0);
        step("saw_wrap_ch1", 1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b1, 24'h0, 1'b1);

        // Collision: saw+clear written to ch0 while ch0 square is popped.
        step("col_cfg", 1'b0, 1'b1, 2'd3, 32'h4000_0000, 1'b1, 1'b0, 24'h0, 1'b0);
        step("col_pre", 1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b1, 24'h7FFFFF, 1'b0);
        step("col_pre_ch1", 1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b1, 24'h0, 1'b1);
        step("col_hit", 1'b1, 1'b1, 2'd2, 32'h0100_0000, 1'b1, 1'b1, 24'h7FFFFF, 1'b0);
        step("col_ch1", 1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b1, 24'h0, 1'b1);
        step("col_after", 1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b1, 24'h800000, 1'b0);
        step("col_after_ch1", 1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b1, 24'h0, 1'b1);
        step("col_newinc", 1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b1, 24'h810000, 1'b0);

        // Reset mid-stream with pop and config write pending (cur is 1 here).
        rst = 1'b1;
        step("rst_mid", 1'b1, 1'b1, 2'd3, 32'h4000_0000, 1'b0, 1'b0, 24'h0, 1'b0);
        rst = 1'b0;
        step("rst_idle", 1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 24'h0, 1'b0);
        step("rst_pop", 1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b1, 24'h0, 1'b0);
        step("rst_pop_ch1", 1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b1, 24'h0, 1'b1);
        step("rst_end", 1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 24'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wavegen.md
# wavegen

Parametrised multi-channel test-tone generator for the mixer datapath; the successor to the single triangle-only synth source. It holds one phase accumulator per channel and produces triangle, sawtooth, square or silence per channel. A runtime config port sets mode and frequency. Samples leave through the same pop/ack pull handshake, with channels served round-robin.

## Interface
- WIDTH, 24: sample width, two's complement.
- NCH, 2: number of channels (1..16).
- ACC_W, 32: phase accumulator width (ACC_W >= WIDTH+1).
- CH_W, 1: channel index width; the integrator sets CH_W >= max(1, clog2(NCH)).

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- pop_i  in  1  request one sample for the current channel.
- ack_o  out  1  sample valid, one cycle after pop_i.
- data_o  out  WIDTH  sample; forced to 0 when ack_o=0.
- ch_o  out  CH_W  channel index of data_o; 0 when ack_o=0.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  CH_W  target channel; writes with cfg_ch >= NCH are ignored.
- cfg_mode  in  2  0 silent, 1 triangle, 2 sawtooth, 3 square.
- cfg_inc  in  ACC_W  phase increment per sample.
- cfg_clr  in  1  on write, also zero that channel's phase.
- cfg_shift  in  3  amplitude attenuation (right shift); present only with WAVEGEN_AMP_EN.

## Operation
- Per-channel state: phase[ACC_W], inc[ACC_W], mode[2], plus shift[3] when WAVEGEN_AMP_EN is defined. Global state: channel pointer cur.
- On pop_i:
  - Compute the sample for channel cur from its pre-update phase.
  - Set phase[cur] <= phase[cur] + inc[cur], mod 2^ACC_W.
  - Set cur <= (cur == NCH-1) ? 0 : cur+1.
  - Register the sample, set ch_o <= cur, set ack_o <= 1.
- Without pop_i: ack_o <= 0 and no state changes.
- Waveform math (p = phase; MSB = bit ACC_W-1; H = 2^(WIDTH-1)):
  - Silent: 0.
  - Saw: t = p[ACC_W-1 -: WIDTH]; sample = t ^ H. Ramps from -H to H-1.
  - Square: MSB=0 gives H-1; MSB=1 gives -(H-1).
  - Triangle: u = p[ACC_W-2 -: WIDTH]; sample = (MSB ? ~u : u) ^ H.
- Config write: mode, inc and shift load on the clock edge. cfg_clr=1 zeroes phase[cfg_ch].
- Simultaneous cfg write and pop on the same channel:
  - The pop uses the old mode/inc/shift.
  - The new values apply from that channel's next pop.
  - cfg_clr wins over the accumulator update, so the phase becomes 0.
- Back-to-back pops every cycle are legal; ack_o then stays high continuously.

## Timing
- Latency: pop_i at edge n gives ack_o/data_o/ch_o valid for the cycle after edge n (one register stage).
- Reset values: ack_o=0, data_o=0, ch_o=0, cur=0, and every phase, inc, mode and shift at 0.
- Reset mid-stream: rst overrides a concurrent pop_i and cfg_we. The following cycle has ack_o=0, and the next pop returns channel 0 from phase 0.
- There is no backpressure and no stall: every pop is answered exactly once.

## Configuration
- WAVEGEN_AMP_EN
  - Defined: cfg_shift port and per-channel shift registers exist. The final sample is arithmetically shifted right by shift[cur] (0..7) before it is registered.
  - Undefined: no port and no registers; every channel outputs full scale.

## Test plan
- Reset, all modes silent, 5 consecutive pops: ack_o high for 5 cycles, data_o=0 throughout, ch_o=0,1,0,1,0. Idle cycles show ack_o=0 and data_o=0.
- NCH=2, ch0 saw, inc=0x01000000:
  - Successive ch0 samples read 0x800000, 0x810000, 0x820000, …
  - After 256 ch0 pops the sequence wraps back to 0x800000.
  - ch1 (silent) stays 0.
- ch0 square, inc=0x40000000: ch0 sequence 0x7FFFFF, 0x7FFFFF, 0x800001, 0x800001, then repeats.
- ch0 triangle, inc=0x40000000: ch0 sequence 0x800000, 0x000000, 0x7FFFFF, 0xFFFFFF, then repeats.
- Collisions and reset:
  - cfg write (mode=saw, cfg_clr=1) to ch0 in the same cycle as a ch0 square pop: the returned sample is still square, and the next ch0 sample is 0x800000.
  - rst asserted mid-stream with pop_i high: no ack the following cycle, and the next pop returns ch_o=0 with data 0.
- With WAVEGEN_AMP_EN defined, ch0 square with shift=4: samples read 0x07FFFF and 0xF80000.
